// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one ALU through round-robin
// arbitration. One operation is in flight at a time; results are registered
// and handed back to the granted requester with a valid/ready handshake.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; grants combinationally and latches operands
// EXEC  | latched operands drive the shared ALU; result captured at the edge
// RESP  | result held for the granted requester until its rsp_ready

module alu_share_alu (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  ctrl_i,
    output logic [31:0] result_o,
    output logic        err_o
);

    // Combinational ALU; unsupported codes report an error and a zero result.
    always_comb begin
        result_o = 32'd0;
        err_o    = 1'b0;
        unique case (ctrl_i)
            4'b0000: result_o = a_i & b_i;
            4'b0001: result_o = a_i | b_i;
            4'b0010: result_o = a_i + b_i;
            4'b0110: result_o = a_i - b_i;
            4'b0111: result_o = (a_i < b_i) ? 32'd1 : 32'd0;
            4'b1100: result_o = a_i | ~b_i;
            default: err_o    = 1'b1;
        endcase
    end

endmodule

module alu_share_arbiter #(
    parameter int unsigned RR_RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_data1,
    input  logic [31:0] req1_data1,
    input  logic [31:0] req0_read2,
    input  logic [31:0] req1_read2,
    input  logic [31:0] req0_instruction,
    input  logic [31:0] req1_instruction,
    input  logic        req0_source,
    input  logic        req1_source,
    input  logic [3:0]  req0_ctrl_alu,
    input  logic [3:0]  req1_ctrl_alu,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic PRIO_INIT = (RR_RESET_PRIO != 0) ? 1'b1 : 1'b0;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        grant_q, grant_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;

    logic        grant_c;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  sel_ctrl;
    logic [31:0] alu_result;
    logic        alu_err;

    // Only the low half of the instruction carries the immediate.
    logic unused_instr_hi;
    assign unused_instr_hi = ^{req0_instruction[31:16], req1_instruction[31:16]};

    // Winner is the priority index if it is requesting, otherwise the other one.
    assign grant_c = req_valid[prio_q] ? prio_q : ~prio_q;

    // Operand selection for the candidate winner, immediate sign-extended.
    always_comb begin
        if (grant_c) begin
            sel_a    = req1_data1;
            sel_b    = req1_source ? {{16{req1_instruction[15]}}, req1_instruction[15:0]}
                                   : req1_read2;
            sel_ctrl = req1_ctrl_alu;
        end else begin
            sel_a    = req0_data1;
            sel_b    = req0_source ? {{16{req0_instruction[15]}}, req0_instruction[15:0]}
                                   : req0_read2;
            sel_ctrl = req0_ctrl_alu;
        end
    end

    alu_share_alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .ctrl_i   (ctrl_q),
        .result_o (alu_result),
        .err_o    (alu_err)
    );

    // Next-state, latch enables and handshake outputs.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        grant_d   = grant_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        result_d  = result_q;
        zero_d    = zero_q;
        err_d     = err_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant_c ? 2'b10 : 2'b01;
                    grant_d   = grant_c;
                    prio_d    = ~grant_c;
                    a_d       = sel_a;
                    b_d       = sel_b;
                    ctrl_d    = sel_ctrl;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_err ? 32'd0 : alu_result;
                zero_d   = alu_err ? 1'b1 : (alu_result == 32'd0);
                err_d    = alu_err;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid = grant_q ? 2'b10 : 2'b01;
                if (rsp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prio_q   <= PRIO_INIT;
            grant_q  <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            ctrl_q   <= 4'd0;
            result_q <= 32'd0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: table of single operations plus
// hand-written sequences for latency, round-robin, back-pressure and reset.

module tb_alu_share_arbiter;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_ORN = 4'b1100;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_data1, req1_data1, req0_read2, req1_read2;
    logic [31:0] req0_instruction, req1_instruction;
    logic        req0_source, req1_source;
    logic [3:0]  req0_ctrl_alu, req1_ctrl_alu;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_err, busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  vld;
        logic [31:0] res;
        logic        z;
        logic        e;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic        idx;
        logic [31:0] d1;
        logic [31:0] r2;
        logic [31:0] ins;
        logic        src;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        z;
        logic        e;
    } vec_t;

    vec_t vecs[12];

    alu_share_arbiter #(.RR_RESET_PRIO(0)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req0_data1       (req0_data1),
        .req1_data1       (req1_data1),
        .req0_read2       (req0_read2),
        .req1_read2       (req1_read2),
        .req0_instruction (req0_instruction),
        .req1_instruction (req1_instruction),
        .req0_source      (req0_source),
        .req1_source      (req1_source),
        .req0_ctrl_alu    (req0_ctrl_alu),
        .req1_ctrl_alu    (req1_ctrl_alu),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_result       (rsp_result),
        .rsp_zero         (rsp_zero),
        .rsp_err          (rsp_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        #2;
        if (!reset && (rsp_valid & rsp_ready) != 2'b00) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_response");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.vld});
                check("rsp_result", rsp_result, e.res);
                check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.z});
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.e});
            end
        end
    end

    task automatic set_req(input logic idx, input logic [31:0] d1, input logic [31:0] r2,
                           input logic [31:0] ins, input logic src, input logic [3:0] ctrl);
        if (idx) begin
            req1_data1 = d1; req1_read2 = r2; req1_instruction = ins;
            req1_source = src; req1_ctrl_alu = ctrl;
        end else begin
            req0_data1 = d1; req0_read2 = r2; req0_instruction = ins;
            req0_source = src; req0_ctrl_alu = ctrl;
        end
    endtask

    // Waits (bounded) until the scoreboard has drained, ending in an IDLE cycle.
    task automatic wait_drain(input string name);
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            fail_now({name, "_timeout"});
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Issues one operation from a table record; called at a falling edge.
    task automatic do_req(input vec_t v, input string name);
        logic       got;
        logic [1:0] oh;
        oh  = v.idx ? 2'b10 : 2'b01;
        got = 1'b0;
        set_req(v.idx, v.d1, v.r2, v.ins, v.src, v.ctrl);
        req_valid = oh;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready != 2'b00) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            fail_now({name, "_accept_timeout"});
        end else begin
            check({name, "_req_ready"}, {30'd0, req_ready}, {30'd0, oh});
            exp_q.push_back('{vld: oh, res: v.res, z: v.z, e: v.e});
        end
        @(negedge clk);
        req_valid = 2'b00;
        wait_drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int last;
        logic stable_ok;

        //            idx   data1          read2          instruction    src   ctrl    result         z     e
        vecs[0]  = '{1'b1, 32'd3,         32'd7,         32'd0,         1'b0, OP_SUB, 32'hFFFFFFFC, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, OP_SLT, 32'd0,        1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'd9,         32'd4,         32'd0,         1'b0, 4'b0101, 32'd0,       1'b1, 1'b1};
        vecs[3]  = '{1'b1, 32'hF0F0F0F0,  32'h0FF00FF0,  32'd0,         1'b0, OP_AND, 32'h00F000F0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h12340000,  32'h00005678,  32'd0,         1'b0, OP_OR,  32'h12345678, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'd0,         32'hFFFFFFFF,  32'd0,         1'b0, OP_ORN, 32'd0,        1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'd1,         32'd2,         32'd0,         1'b0, OP_SLT, 32'd1,        1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, OP_ADD, 32'd0,        1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'd0,         32'h12345678,  32'h00008000,  1'b1, OP_SUB, 32'h00008000, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'd5,         32'd5,         32'd0,         1'b0, 4'b1111, 32'd0,       1'b1, 1'b1};
        vecs[10] = '{1'b0, 32'd1,         32'hDEADBEEF,  32'hABCD7FFF,  1'b1, OP_ADD, 32'h00008000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'd2,         32'd3,         32'h0000FFFF,  1'b0, OP_ADD, 32'd5,        1'b0, 1'b0};

        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        set_req(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_req(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_req_ready", {30'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // ADD with negative immediate, checking two-cycle latency.
        set_req(1'b0, 32'd5, 32'd0, 32'h0000FFFB, 1'b1, OP_ADD);
        rsp_ready = 2'b01;
        req_valid = 2'b01;
        #1;
        check("lat_req_ready", {30'd0, req_ready}, 32'd1);
        exp_q.push_back('{vld: 2'b01, res: 32'd0, z: 1'b1, e: 1'b0});
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("lat_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("lat_exec_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        #1;
        check("lat_resp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        wait_drain("lat");

        rsp_ready = 2'b11;
        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Round-robin from reset with both requesters always valid.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(1'b0, 32'd10, 32'd20, 32'd0, 1'b0, OP_ADD);
        set_req(1'b1, 32'd100, 32'd1, 32'd0, 1'b0, OP_SUB);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        n = 0;
        last = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                check("rr_grant", {30'd0, req_ready}, (n % 2 == 0) ? 32'd1 : 32'd2);
                if (n > 0) check("rr_interval", c - last, 32'd3);
                last = c;
                if (req_ready[0]) exp_q.push_back('{vld: 2'b01, res: 32'd30, z: 1'b0, e: 1'b0});
                else              exp_q.push_back('{vld: 2'b10, res: 32'd99, z: 1'b0, e: 1'b0});
                n++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        if (n < 6) fail_now("rr_grant_timeout");
        wait_drain("rr");

        // Back-pressure in RESP while req1 waits; after reset above, prio is 0.
        set_req(1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 1'b0, OP_AND);
        set_req(1'b1, 32'h00000F00, 32'h0000000F, 32'd0, 1'b0, OP_OR);
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        #1;
        check("hold_accept0", {30'd0, req_ready}, 32'd1);
        exp_q.push_back('{vld: 2'b01, res: 32'h0000F000, z: 1'b0, e: 1'b0});
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rsp_valid !== 2'b01 || rsp_result !== 32'h0000F000 || rsp_zero !== 1'b0 ||
                req_ready !== 2'b00 || busy !== 1'b1) begin
                stable_ok = 1'b0;
                $display("FAIL hold_cycle%0d: rsp_valid=%b result=%h req_ready=%b busy=%b",
                         i, rsp_valid, rsp_result, req_ready, busy);
            end
            @(negedge clk);
        end
        check("hold_stable", {31'd0, stable_ok}, 32'd1);
        check("hold_queue_pending", exp_q.size(), 32'd1);
        rsp_ready = 2'b01;
        #1;
        check("hold_release_req_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("hold_req1_accept", {30'd0, req_ready}, 32'd2);
        exp_q.push_back('{vld: 2'b10, res: 32'h00000F0F, z: 1'b0, e: 1'b0});
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        wait_drain("hold");

        // Reset while in EXEC drops the operation.
        set_req(1'b0, 32'd1, 32'd1, 32'd0, 1'b0, OP_ADD);
        req_valid = 2'b01;
        #1;
        check("rst_exec_accept", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_exec_busy", {31'd0, busy}, 32'd0);
        check("rst_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        stable_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 2'b00) stable_ok = 1'b0;
        end
        check("rst_exec_no_response", {31'd0, stable_ok}, 32'd1);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one instance of the team's `ALU` module between two requesters (e.g. the main datapath and the address/branch unit) with valid/ready handshakes on both request and response sides. It arbitrates round-robin, latches the winner's operands, runs the operation through the shared ALU, and returns a registered result to the granted requester. One operation is in flight at a time.

## Interface
- `RR_RESET_PRIO`, default 0: requester index that holds priority after reset.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  bit i = requester i presents an operation.
- `req_ready`  out  2  bit i = operation i accepted this cycle; one-hot or zero.
- `req0_data1`, `req1_data1`  in  32  operand A.
- `req0_read2`, `req1_read2`  in  32  register operand B.
- `req0_instruction`, `req1_instruction`  in  32  instruction; bits [15:0] form the immediate.
- `req0_source`, `req1_source`  in  1  0 = B from `readN`, 1 = B from sign-extended immediate.
- `req0_ctrl_alu`, `req1_ctrl_alu`  in  4  ALU operation code.
- `rsp_valid`  out  2  bit i = result for requester i is held on the `rsp_*` outputs.
- `rsp_ready`  in  2  bit i = requester i consumes its result.
- `rsp_result`  out  32  registered ALU result.
- `rsp_zero`  out  1  registered zero flag (1 iff `rsp_result` == 0).
- `rsp_err`  out  1  1 = unsupported `ctrl_alu`.
- `busy`  out  1  1 whenever state != IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any `req_valid`, grant = priority index if its valid is set, else the other index. Assert `req_ready[grant]` combinationally in that cycle. At the edge, latch grant index and all its request fields, then go to EXEC. Priority pointer becomes the non-granted index (the index that lost, or the other index if only one requested).
- EXEC: the latched fields drive the shared ALU. At the edge, capture the result, zero flag and error flag into the `rsp_*` registers, then go to RESP.
- RESP: `rsp_valid[grant]`=1. `rsp_result`, `rsp_zero` and `rsp_err` stay stable. When `rsp_ready[grant]`=1, go to IDLE. `rsp_ready` of the non-granted bit is ignored.
- Supported codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (unsigned compare, result 1/0), 1100 = A | ~B.
- Any other code: `rsp_result`=0, `rsp_zero`=1, `rsp_err`=1. The ALU output is ignored for that op.
- Immediate: B = {{16{instruction[15]}}, instruction[15:0]}.
- Arithmetic is modulo 2^32. Overflow and carry are discarded.

## Timing
- Reset values: state IDLE, priority = `RR_RESET_PRIO`, `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_err`=0, `busy`=0.
- Reset mid-operation (EXEC or RESP): the operation is dropped and no response is issued. The next cycle is IDLE.
- Latency: for an accept at edge T, `rsp_valid` goes high in the cycle after edge T+1 (two cycles after accept).
- Minimum issue interval is 3 cycles (accept, EXEC, RESP with `rsp_ready` already high).
- `req_ready` is only ever high in IDLE. A requester must hold `req_valid` and its fields stable until `req_ready`. Dropping `req_valid` before grant has no effect.
- A request arriving while busy waits. It is granted in the first IDLE cycle; if both requesters are pending, the priority pointer decides.
- `rsp_ready` high before `rsp_valid` rises: the handshake completes on the first RESP cycle.
- The `rsp_*` outputs hold their last values in IDLE. Only `rsp_valid` indicates validity.

## Test plan
- Reset, then req0 ADD, data1=5, source=1, instruction[15:0]=0xFFFB, `rsp_ready[0]`=1 -> `req_ready`=01 on the accept cycle; two cycles later `rsp_valid`=01, `rsp_result`=0, `rsp_zero`=1, `rsp_err`=0.
- req1 SUB, data1=3, read2=7, source=0 -> `rsp_valid`=10, `rsp_result`=0xFFFFFFFC, `rsp_zero`=0.
- Both requesters valid continuously with `rsp_ready`=11, `RR_RESET_PRIO`=0 -> grants alternate 0,1,0,1, one accept every 3 cycles; no request starves.
- req0 SLT with data1=0xFFFFFFFF, read2=1 -> `rsp_result`=0; then `ctrl_alu`=0101 -> `rsp_result`=0, `rsp_zero`=1, `rsp_err`=1.
- Hold `rsp_ready`=0 for 5 cycles in RESP while req1 is valid -> result stays stable, `req_ready` stays 00, `busy`=1; after `rsp_ready[0]`=1, req1 is accepted in the following IDLE cycle.
- Assert `reset` during EXEC -> the next cycle has `busy`=0, `rsp_valid`=00, and no response for the dropped op.
